// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-add multiplier controller.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } ctrl_state_t;

  localparam int N_DEFAULT = 8;

endpackage

// File: rtl/step_counter.sv
// Add/shift step counter: synchronous clear, saturating increment, terminal flag at N-1.
module step_counter #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_term
);

  logic [W-1:0] r_cnt;

  assign o_term = (r_cnt == W'(N - 1));

  // Step count; holding at N-1 keeps wrap-around unreachable.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_term) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/mult_ctrl.sv
// Sequencing controller for the shift-add 2's complement multiplier datapath.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Ld_B,
  output logic Clr_AX,
  output logic Ld_A,
  output logic Fn,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  ctrl_state_t r_state;
  ctrl_state_t w_next;
  logic        w_term;
  logic        w_cnt_clr;
  logic        w_cnt_inc;

  assign w_cnt_clr = (r_state == CLEAR);
  assign w_cnt_inc = (r_state == SHIFT);

  step_counter #(.N(N)) u_step (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_term  (w_term)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; the load request outranks Run only while idle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (ClearA_LoadB) w_next = IDLE;
        else if (Run)     w_next = CLEAR;
        else              w_next = IDLE;
      end
      CLEAR: w_next = ADD;
      ADD:   w_next = SHIFT;
      SHIFT: begin
        if (w_term) w_next = HOLD;
        else        w_next = ADD;
      end
      HOLD: begin
        if (Run) w_next = HOLD;
        else     w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Strobe decode; M is a registered datapath bit, so Ld_A/Fn form no loop.
  // The IDLE load strobes are gated by Reset_n so reset silences every output at once.
  always_comb begin
    Ld_B     = 1'b0;
    Clr_AX   = 1'b0;
    Ld_A     = 1'b0;
    Fn       = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (ClearA_LoadB && Reset_n) begin
          Ld_B   = 1'b1;
          Clr_AX = 1'b1;
        end else begin
          Ld_B   = 1'b0;
          Clr_AX = 1'b0;
        end
      end
      CLEAR: begin
        Clr_AX = 1'b1;
        Busy   = 1'b1;
      end
      ADD: begin
        Ld_A = M;
        Fn   = M & w_term;
        Busy = 1'b1;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
      end
      HOLD:    Done = 1'b1;
      default: Done = 1'b0;
    endcase
  end

endmodule
